// File: rtl/life_support_pkg.sv
// Shared types and constants for the life-support power controller:
// FSM state encoding, level width, and per-state output decode.
package life_support_pkg;

    localparam int unsigned N = 5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StGntDef = 3'd1,
        StGntSth = 3'd2,
        StCool   = 3'd3,
        StFault  = 3'd4
    } state_e;

    typedef struct packed {
        logic       pwr;
        logic       def;
        logic       sth;
        logic [1:0] gnt;
        logic       fault;
        logic       busy;
    } ctrl_out_t;

    localparam logic [1:0] GntNone = 2'b00;
    localparam logic [1:0] GntDef  = 2'b01;
    localparam logic [1:0] GntSth  = 2'b10;

    localparam ctrl_out_t OutIdle  = '{pwr: 1'b0, def: 1'b0, sth: 1'b0, gnt: GntNone,
                                       fault: 1'b0, busy: 1'b0};
    localparam ctrl_out_t OutDef   = '{pwr: 1'b1, def: 1'b1, sth: 1'b0, gnt: GntDef,
                                       fault: 1'b0, busy: 1'b1};
    localparam ctrl_out_t OutSth   = '{pwr: 1'b1, def: 1'b0, sth: 1'b1, gnt: GntSth,
                                       fault: 1'b0, busy: 1'b1};
    localparam ctrl_out_t OutCool  = '{pwr: 1'b0, def: 1'b0, sth: 1'b0, gnt: GntNone,
                                       fault: 1'b0, busy: 1'b1};
    localparam ctrl_out_t OutFault = '{pwr: 1'b0, def: 1'b0, sth: 1'b0, gnt: GntNone,
                                       fault: 1'b1, busy: 1'b1};

    function automatic ctrl_out_t decode_out(state_e st);
        ctrl_out_t o;
        unique case (st)
            StIdle:   o = OutIdle;
            StGntDef: o = OutDef;
            StGntSth: o = OutSth;
            StCool:   o = OutCool;
            StFault:  o = OutFault;
            default:  o = OutIdle;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester not granted last wins.
// The pointer only advances when the caller commits a grant via take.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_def,
    input  logic req_sth,
    input  logic take,
    output logic gnt_def,
    output logic gnt_sth
);

    logic last_sth_q;

    assign gnt_def = req_def & (~req_sth | last_sth_q);
    assign gnt_sth = req_sth & (~req_def | ~last_sth_q);

    // Reset to "last was sth" so def wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sth_q <= 1'b1;
        end else if (take) begin
            last_sth_q <= gnt_sth;
        end
    end

endmodule

// File: rtl/life_support_ctrl.sv
// Life-support power sequencer: arbitrates shield/thermal power grants with
// bounded hold time, a cool-down gap, and an overheat lockout. Moore outputs.
module life_support_ctrl
    import life_support_pkg::*;
#(
    parameter int unsigned   N            = life_support_pkg::N,
    parameter int unsigned   GRANT_CYCLES = 8,
    parameter int unsigned   COOL_CYCLES  = 2,
    parameter logic [N-1:0]  TEMP_SAFE    = 5'd24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_def,
    input  logic         req_sth,
    input  logic [N-1:0] shield_lvl,
    input  logic [N-1:0] temp_lvl,
    input  logic [N-1:0] shield_max,
    output logic         pwr,
    output logic         def,
    output logic         sth,
    output logic [1:0]   gnt,
    output logic         fault,
    output logic         busy
);

    localparam int unsigned CntMax = (GRANT_CYCLES > COOL_CYCLES) ? GRANT_CYCLES : COOL_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] GrantLast = CntW'(GRANT_CYCLES);
    localparam logic [CntW-1:0] CoolLast  = CntW'(COOL_CYCLES);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] hold_q, hold_d;
    logic [CntW-1:0] cool_q, cool_d;
    logic            arb_def, arb_sth, arb_take;
    logic            overheat, temp_ok, shield_full;
    ctrl_out_t       out;

    assign overheat    = &temp_lvl;
    assign temp_ok     = temp_lvl < TEMP_SAFE;
    assign shield_full = shield_lvl >= shield_max;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_def (req_def),
        .req_sth (req_sth),
        .take    (arb_take),
        .gnt_def (arb_def),
        .gnt_sth (arb_sth)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cool_d   = cool_q;
        arb_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_def) begin
                    state_d  = StGntDef;
                    hold_d   = CntOne;
                    arb_take = 1'b1;
                end else if (arb_sth) begin
                    state_d  = StGntSth;
                    hold_d   = CntOne;
                    arb_take = 1'b1;
                end
            end
            StGntDef: begin
                if (!req_def || hold_q == GrantLast || shield_full) begin
                    state_d = StCool;
                    cool_d  = CntOne;
                end else begin
                    hold_d = hold_q + CntOne;
                end
            end
            StGntSth: begin
                if (!req_sth || hold_q == GrantLast) begin
                    state_d = StCool;
                    cool_d  = CntOne;
                end else begin
                    hold_d = hold_q + CntOne;
                end
            end
            StCool: begin
                if (cool_q == CoolLast) begin
                    state_d = StIdle;
                    cool_d  = '0;
                end else begin
                    cool_d = cool_q + CntOne;
                end
            end
            StFault: begin
                if (temp_ok) begin
                    state_d = StCool;
                    cool_d  = CntOne;
                end
            end
            default: state_d = StIdle;
        endcase

        // Overheat pre-empts everything, including a grant being committed this cycle.
        if (overheat && state_q != StFault) begin
            state_d  = StFault;
            arb_take = 1'b0;
            hold_d   = '0;
            cool_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            hold_q  <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
        end
    end

    assign out   = decode_out(state_q);
    assign pwr   = out.pwr;
    assign def   = out.def;
    assign sth   = out.sth;
    assign gnt   = out.gnt;
    assign fault = out.fault;
    assign busy  = out.busy;

endmodule

// File: tb/tb_life_support_ctrl.sv
// Directed bench for life_support_ctrl: grant timing, round-robin, shield
// cut-off, overheat lockout, and asynchronous reset.
module tb_life_support_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_def = 1'b0;
    logic       req_sth = 1'b0;
    logic [4:0] shield_lvl = '0;
    logic [4:0] temp_lvl = '0;
    logic [4:0] shield_max = 5'd31;
    logic       pwr, def, sth, fault, busy;
    logic [1:0] gnt;
    logic [6:0] obs;

    int checks = 0;
    int failures = 0;

    // {pwr, def, sth, gnt[1:0], fault, busy}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_DEF   = 7'b1100101;
    localparam logic [6:0] E_STH   = 7'b1011001;
    localparam logic [6:0] E_COOL  = 7'b0000001;
    localparam logic [6:0] E_FAULT = 7'b0000011;

    assign obs = {pwr, def, sth, gnt, fault, busy};

    life_support_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_def    (req_def),
        .req_sth    (req_sth),
        .shield_lvl (shield_lvl),
        .temp_lvl   (temp_lvl),
        .shield_max (shield_max),
        .pwr        (pwr),
        .def        (def),
        .sth        (sth),
        .gnt        (gnt),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    a_excl: assert property (@(negedge clk) !(def && sth))
        else $display("FAIL excl def=%b sth=%b required not both 1", def, sth);
    a_onehot: assert property (@(negedge clk) (gnt !== 2'b11) && (gnt === {sth, def}))
        else $display("FAIL onehot gnt=%b required one-hot/zero matching {sth,def}=%b%b",
                      gnt, sth, def);

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b1;
        req_def = 1'b0;
        req_sth = 1'b0;
        shield_lvl = '0;
        temp_lvl = '0;
        shield_max = 5'd31;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_async obs=%b required=%b", obs, E_IDLE);
        end
        req_def = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_hold obs=%b required=%b", obs, E_IDLE);
        end
        rst = 1'b0;
        req_def = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_idle obs=%b required=%b", obs, E_IDLE);
        end
    endtask

    task automatic test_hold_limit();
        logic [6:0] exp;
        do_reset();
        req_def = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp = (i < 8) ? E_DEF : (i < 10) ? E_COOL : (i == 10) ? E_IDLE : E_DEF;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL hold[%0d] obs=%b required=%b", i, obs, exp);
            end
        end
        req_def = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = (i < 2) ? E_COOL : E_IDLE;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL hold_drop[%0d] obs=%b required=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] exp;
        do_reset();
        req_def = 1'b1;
        req_sth = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i < 8)       exp = E_DEF;
            else if (i < 10) exp = E_COOL;
            else if (i < 11) exp = E_IDLE;
            else if (i < 19) exp = E_STH;
            else if (i < 21) exp = E_COOL;
            else if (i < 22) exp = E_IDLE;
            else             exp = E_DEF;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rr[%0d] obs=%b required=%b", i, obs, exp);
            end
        end
        req_def = 1'b0;
        req_sth = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = (i < 2) ? E_COOL : E_IDLE;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rr_tail[%0d] obs=%b required=%b", i, obs, exp);
            end
        end
    endtask

    task automatic test_shield_cutoff();
        logic [6:0] exp;
        do_reset();
        shield_max = 5'd24;
        shield_lvl = 5'd20;
        req_def = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            exp = (i < 4) ? E_DEF : (i < 6) ? E_COOL : E_IDLE;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL shield[%0d] obs=%b required=%b lvl=%0d", i, obs, exp, shield_lvl);
            end
            if (i < 4) shield_lvl = shield_lvl + 5'd1;
            if (i == 4) req_def = 1'b0;
        end
    endtask

    task automatic test_overheat();
        logic [6:0] exp_seq [8];
        exp_seq = '{E_STH, E_FAULT, E_FAULT, E_COOL, E_COOL, E_IDLE, E_FAULT, E_COOL};
        do_reset();
        req_sth = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL overheat[%0d] obs=%b required=%b temp=%0d",
                         i, obs, exp_seq[i], temp_lvl);
            end
            unique case (i)
                0: temp_lvl = 5'd31;
                1: temp_lvl = 5'd24;
                2: temp_lvl = 5'd23;
                3: req_sth = 1'b0;
                5: begin temp_lvl = 5'd31; req_def = 1'b1; end
                6: begin temp_lvl = 5'd0; req_def = 1'b0; end
                default: ;
            endcase
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [6:0] exp;
        do_reset();
        req_sth = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_STH) begin
            failures++;
            $display("FAIL areset_grant obs=%b required=%b", obs, E_STH);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL areset_drop obs=%b required=%b", obs, E_IDLE);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_STH) begin
            failures++;
            $display("FAIL areset_regrant obs=%b required=%b", obs, E_STH);
        end
        req_sth = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = (i < 2) ? E_COOL : E_IDLE;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL areset_tail[%0d] obs=%b required=%b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_limit();
        test_round_robin();
        test_shield_cutoff();
        test_overheat();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_support_ctrl.md
LIFE_SUPPORT_CTRL -- requirements
Module: life_support_ctrl

Interface
REQ-001 Parameter N, default 5, shield/temperature level width.
REQ-002 Parameter GRANT_CYCLES, default 8, maximum consecutive cycles one requester holds power.
REQ-003 Parameter COOL_CYCLES, default 2, unpowered gap between grants.
REQ-004 Parameter TEMP_SAFE, default 5'd24, temperature below which a fault clears.
REQ-005 clk  input  1  single clock, all state on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_def  input  1  shield-boost request.
REQ-008 req_sth  input  1  thermal-drive request.
REQ-009 shield_lvl  input  N  current shield counter value.
REQ-010 temp_lvl  input  N  current temperature counter value.
REQ-011 shield_max  input  N  shield target; grant ends at or above it.
REQ-012 pwr  output  1  power enable to counter datapath.
REQ-013 def  output  1  shield count-up command.
REQ-014 sth  output  1  temperature count-up command.
REQ-015 gnt  output  2  one-hot grant {sth,def}; 2'b00 when none.
REQ-016 fault  output  1  overheat lockout active.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, GNT_DEF, GNT_STH, COOL, FAULT; all outputs SHALL be decoded from registered state only (Moore, no input-to-output paths).
REQ-019 Outputs per state: IDLE all 0; GNT_DEF pwr=1 def=1 gnt=01; GNT_STH pwr=1 sth=1 gnt=10; COOL all 0 except busy; FAULT fault=1 busy=1, others 0.
REQ-020 IDLE: one request -> that grant next cycle; both requests -> the requester not granted last (round-robin pointer); none -> stay.
REQ-021 Round-robin pointer SHALL update on every entry into a GNT state.
REQ-022 Grant hold counter SHALL start at 1 on GNT entry and increment per cycle; grant exits to COOL when its request drops, counter reaches GRANT_CYCLES, or (GNT_DEF only) shield_lvl >= shield_max, whichever first.
REQ-023 Grant length SHALL therefore be 1..GRANT_CYCLES cycles; it SHALL never exceed GRANT_CYCLES even with the request held.
REQ-024 COOL SHALL last exactly COOL_CYCLES cycles, then return to IDLE; requests during COOL are not latched, only sampled in IDLE.
REQ-025 Overheat: temp_lvl equal to all-ones in any non-FAULT state -> FAULT next cycle, overriding every other transition.
REQ-026 FAULT exits to COOL when temp_lvl < TEMP_SAFE; requests ignored while in FAULT.
REQ-027 Comparisons SHALL be unsigned N-bit; counters sized to hold max(GRANT_CYCLES, COOL_CYCLES) with no wrap.
REQ-028 gnt SHALL always be one-hot or zero; def and sth SHALL never both be 1.

Reset
REQ-029 rst high SHALL immediately force state IDLE, all outputs 0, hold/cool counters 0, round-robin pointer "last=sth" (def wins first tie).
REQ-030 rst asserted mid-grant SHALL drop pwr/def/sth asynchronously, before the next clock edge.
REQ-031 After rst deasserts, first grant possible on the first posedge with a request present.

Structure
REQ-032 State encoding and output-decode constants SHALL live in a shared package life_support_pkg alongside the level-width constant N.
REQ-033 One sub-module, rr_arb2 (two-input round-robin arbiter with pointer register), SHALL implement REQ-020/021; FSM, timers and decode stay in the top.

Verification
REQ-034 Reset, then req_def=1, shield_lvl=0, shield_max=31 held -> GNT_DEF for exactly 8 cycles, COOL 2 cycles, GNT_DEF again.
REQ-035 req_def=req_sth=1 from IDLE after reset -> GNT_DEF first, then after COOL GNT_STH, alternating thereafter.
REQ-036 GNT_DEF with shield_lvl stepping to 24, shield_max=24 -> exit to COOL the cycle after shield_lvl reaches 24.
REQ-037 GNT_STH, temp_lvl driven to 31 -> FAULT next cycle, pwr=0 fault=1; temp_lvl=23 -> COOL, then IDLE.
REQ-038 rst pulsed mid-GNT_STH between clock edges -> pwr and sth fall without a clock edge; gnt=00, busy=0.
REQ-039 All scenarios: assertion that def&sth is never 1 and gnt is never 2'b11.
